// File: rtl/io_reg_pkg.sv
// Shared types and sizing helpers for the input-register bank controller.
package io_reg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        APPLY,
        SETTLE,
        DONE
    } cfg_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The timer loads (cycles - 1), so $clog2 of the larger phase length is enough.
    function automatic int cnt_w(input int rst_cycles, input int settle_cycles);
        int m;
        m = (rst_cycles > settle_cycles) ? rst_cycles : settle_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_w(2, 3);

endpackage

// File: rtl/io_reg_snap.sv
// Samples the cells' IQZ outputs, masks the cell under reconfiguration and
// publishes change-detected snapshots over a valid/ready stream.
module io_reg_snap #(
    parameter int NUM_IO = 8
) (
    input  logic              IQC,
    input  logic              QRT,
    input  logic [NUM_IO-1:0] iqz_i,
    input  logic [NUM_IO-1:0] mask_i,
    output logic              snap_valid,
    input  logic              snap_ready,
    output logic [NUM_IO-1:0] snap_data
);

    logic [NUM_IO-1:0] sample_q, sample_d;
    logic [NUM_IO-1:0] last_q, last_d;
    logic [NUM_IO-1:0] masked;
    logic              valid_q, valid_d;

    assign sample_d = iqz_i;

    always_comb begin
        masked  = (sample_q & ~mask_i) | (last_q & mask_i);
        valid_d = valid_q;
        last_d  = last_q;
        if (valid_q) begin
            if (snap_ready) begin
                valid_d = 1'b0;
            end
        end else if (masked != last_q) begin
            valid_d = 1'b1;
            last_d  = masked;
        end
    end

    always_ff @(posedge IQC or posedge QRT) begin
        if (QRT) begin
            sample_q <= '0;
            last_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            sample_q <= sample_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
        end
    end

    // The last-emitted value is exactly what is on the stream, so one register serves both.
    assign snap_valid = valid_q;
    assign snap_data  = last_q;

endmodule

// File: rtl/io_in_reg_ctrl.sv
// Bank controller: sequences per-cell ISEL/FIXHOLD reconfiguration behind a
// hold-reset / apply / settle handshake and streams IQZ change snapshots.
//
//   state  | meaning
//   IDLE   | ready for a request; bad indices rejected here
//   HOLD   | target cell held in reset for RST_CYCLES
//   APPLY  | new ISEL/FIXHOLD driven, cell still in reset
//   SETTLE | cell released, wait SETTLE_CYCLES
//   DONE   | cfg_done pulse, back to IDLE
module io_in_reg_ctrl
    import io_reg_pkg::*;
#(
    parameter int   NUM_IO        = 8,
    parameter int   RST_CYCLES    = 2,
    parameter int   SETTLE_CYCLES = 3,
    parameter logic ISEL_RST      = 1'b0
) (
    input  logic                     IQC,
    input  logic                     QRT,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [idx_w(NUM_IO)-1:0] cfg_idx,
    input  logic                     cfg_isel,
    input  logic                     cfg_fixhold,
    output logic                     cfg_done,
    output logic                     cfg_err,
    output logic [NUM_IO-1:0]        isel_o,
    output logic [NUM_IO-1:0]        fixhold_o,
    output logic [NUM_IO-1:0]        cell_rst_o,
    input  logic [NUM_IO-1:0]        iqz_i,
    output logic                     snap_valid,
    input  logic                     snap_ready,
    output logic [NUM_IO-1:0]        snap_data
);

    localparam int IDX_W = idx_w(NUM_IO);
    localparam int CNT_W = cnt_w(RST_CYCLES, SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    cfg_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              isel_new_q, isel_new_d;
    logic              fix_new_q, fix_new_d;
    logic [NUM_IO-1:0] isel_q, isel_d;
    logic [NUM_IO-1:0] fixhold_q, fixhold_d;
    logic [NUM_IO-1:0] cell_rst_q, cell_rst_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [NUM_IO-1:0] sel_mask, sel_mask_d;
    logic              accept, idx_bad;

    assign accept   = cfg_valid && ready_q && (state_q == IDLE);
    assign idx_bad  = (int'(cfg_idx) >= NUM_IO);
    assign sel_mask = NUM_IO'(1) << idx_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        isel_new_d = isel_new_q;
        fix_new_d  = fix_new_q;
        isel_d     = isel_q;
        fixhold_d  = fixhold_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (idx_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = HOLD;
                        cnt_d      = RST_LOAD;
                        idx_d      = cfg_idx;
                        isel_new_d = cfg_isel;
                        fix_new_d  = cfg_fixhold;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d   = APPLY;
                    isel_d    = (isel_q & ~sel_mask) | (sel_mask & {NUM_IO{isel_new_q}});
                    fixhold_d = (fixhold_q & ~sel_mask) | (sel_mask & {NUM_IO{fix_new_q}});
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            APPLY: begin
                state_d = SETTLE;
                cnt_d   = SETTLE_LOAD;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Registered outputs are derived from the next state so they line up with it.
        ready_d    = (state_d == IDLE);
        sel_mask_d = NUM_IO'(1) << idx_d;
        cell_rst_d = (state_d == HOLD || state_d == APPLY) ? sel_mask_d : '0;
    end

    always_ff @(posedge IQC or posedge QRT) begin
        if (QRT) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            isel_new_q <= 1'b0;
            fix_new_q  <= 1'b0;
            isel_q     <= {NUM_IO{ISEL_RST}};
            fixhold_q  <= '0;
            cell_rst_q <= '1;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            isel_new_q <= isel_new_d;
            fix_new_q  <= fix_new_d;
            isel_q     <= isel_d;
            fixhold_q  <= fixhold_d;
            cell_rst_q <= cell_rst_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cfg_ready  = ready_q;
    assign cfg_done   = done_q;
    assign cfg_err    = err_q;
    assign isel_o     = isel_q;
    assign fixhold_o  = fixhold_q;
    assign cell_rst_o = cell_rst_q;

    io_reg_snap #(
        .NUM_IO (NUM_IO)
    ) u_snap (
        .IQC        (IQC),
        .QRT        (QRT),
        .iqz_i      (iqz_i),
        .mask_i     ((state_q != IDLE) ? sel_mask : '0),
        .snap_valid (snap_valid),
        .snap_ready (snap_ready),
        .snap_data  (snap_data)
    );

endmodule

// File: tb/tb_io_in_reg_ctrl.sv
// Self-checking bench for io_in_reg_ctrl: reset, config sequencing, bad index,
// snapshot stream with backpressure, masking, abort, and a randomized run.
module tb_io_in_reg_ctrl;

    localparam int RC = 2;
    localparam int SC = 3;
    localparam int LAT = RC + SC + 2;

    logic       IQC = 1'b0;
    logic       QRT = 1'b0;

    logic       cfg_valid, cfg_ready, cfg_isel, cfg_fixhold, cfg_done, cfg_err;
    logic [2:0] cfg_idx;
    logic [7:0] isel_o, fixhold_o, cell_rst_o, iqz_i, snap_data;
    logic       snap_valid, snap_ready;

    logic       cfg_valid_b, cfg_ready_b, cfg_isel_b, cfg_fixhold_b, cfg_done_b, cfg_err_b;
    logic [2:0] cfg_idx_b;
    logic [5:0] isel_b, fixhold_b, cell_rst_b, iqz_b, snap_data_b;
    logic       snap_valid_b, snap_ready_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 IQC = ~IQC;

    io_in_reg_ctrl #(.NUM_IO(8), .RST_CYCLES(RC), .SETTLE_CYCLES(SC), .ISEL_RST(1'b0)) dut (
        .IQC(IQC), .QRT(QRT),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
        .cfg_isel(cfg_isel), .cfg_fixhold(cfg_fixhold),
        .cfg_done(cfg_done), .cfg_err(cfg_err),
        .isel_o(isel_o), .fixhold_o(fixhold_o), .cell_rst_o(cell_rst_o),
        .iqz_i(iqz_i), .snap_valid(snap_valid), .snap_ready(snap_ready), .snap_data(snap_data)
    );

    // Non-power-of-two bank so out-of-range indices are representable.
    io_in_reg_ctrl #(.NUM_IO(6), .RST_CYCLES(RC), .SETTLE_CYCLES(SC), .ISEL_RST(1'b0)) dut_b (
        .IQC(IQC), .QRT(QRT),
        .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b), .cfg_idx(cfg_idx_b),
        .cfg_isel(cfg_isel_b), .cfg_fixhold(cfg_fixhold_b),
        .cfg_done(cfg_done_b), .cfg_err(cfg_err_b),
        .isel_o(isel_b), .fixhold_o(fixhold_b), .cell_rst_o(cell_rst_b),
        .iqz_i(iqz_b), .snap_valid(snap_valid_b), .snap_ready(snap_ready_b), .snap_data(snap_data_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] iqz;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
    } snap_vec_t;

    snap_vec_t tv [16];

    initial begin
        int acc;
        bit have;
        bit seq;
        logic [2:0] midx;
        logic m_isel_new, m_fix_new;
        logic [7:0] m_isel, m_fix, m_samp, m_last, m, m_in, exp_rst;
        bit m_valid;

        // Snapshot sequence: row driven at one negedge, outputs checked at the next.
        tv[0]  = '{8'hA5, 1'b1, 1'b0, 8'h00};
        tv[1]  = '{8'hA5, 1'b1, 1'b1, 8'hA5};
        tv[2]  = '{8'hA5, 1'b1, 1'b0, 8'hA5};
        tv[3]  = '{8'hA5, 1'b1, 1'b0, 8'hA5};
        tv[4]  = '{8'hA5, 1'b1, 1'b0, 8'hA5};
        tv[5]  = '{8'h00, 1'b1, 1'b0, 8'hA5};
        tv[6]  = '{8'h00, 1'b1, 1'b1, 8'h00};
        tv[7]  = '{8'h00, 1'b1, 1'b0, 8'h00};
        tv[8]  = '{8'hA5, 1'b0, 1'b0, 8'h00};
        tv[9]  = '{8'h3C, 1'b0, 1'b1, 8'hA5};
        tv[10] = '{8'hC3, 1'b0, 1'b1, 8'hA5};
        tv[11] = '{8'hC3, 1'b0, 1'b1, 8'hA5};
        tv[12] = '{8'hC3, 1'b1, 1'b0, 8'hA5};
        tv[13] = '{8'hC3, 1'b1, 1'b1, 8'hC3};
        tv[14] = '{8'hC3, 1'b1, 1'b0, 8'hC3};
        tv[15] = '{8'hC3, 1'b1, 1'b0, 8'hC3};

        cfg_valid = 0; cfg_idx = 0; cfg_isel = 0; cfg_fixhold = 0; iqz_i = 0; snap_ready = 1;
        cfg_valid_b = 0; cfg_idx_b = 0; cfg_isel_b = 0; cfg_fixhold_b = 0; iqz_b = 0; snap_ready_b = 1;

        // Reset
        #2 QRT = 1'b1;
        repeat (2) @(negedge IQC);
        chk("rst_isel", isel_o, 8'h00);
        chk("rst_fixhold", fixhold_o, 8'h00);
        chk("rst_cell_rst", cell_rst_o, 8'hFF);
        chk("rst_ready", cfg_ready, 1'b0);
        chk("rst_done", cfg_done, 1'b0);
        chk("rst_snap_valid", snap_valid, 1'b0);
        chk("rst_snap_data", snap_data, 8'h00);
        chk("rst_cell_rst_b", cell_rst_b, 6'h3F);
        QRT = 1'b0;
        @(negedge IQC);
        chk("rel_cell_rst", cell_rst_o, 8'h00);
        chk("rel_ready", cfg_ready, 1'b1);
        repeat (3) @(negedge IQC);

        // Snapshot table incl. backpressure coalescing
        for (int i = 0; i < 16; i++) begin
            iqz_i = tv[i].iqz;
            snap_ready = tv[i].rdy;
            @(negedge IQC);
            chk($sformatf("snap_valid[%0d]", i), snap_valid, tv[i].ev);
            chk($sformatf("snap_data[%0d]", i), snap_data, tv[i].ed);
        end

        // Config idx 3 with a reset glitch on iqz[3] that must stay masked
        snap_ready = 1;
        chk("cfg_ready_pre", cfg_ready, 1'b1);
        cfg_valid = 1; cfg_idx = 3; cfg_isel = 1; cfg_fixhold = 1;
        @(negedge IQC);
        cfg_valid = 0;
        for (int k = 1; k <= 9; k++) begin
            chk($sformatf("cfg_rst[%0d]", k), cell_rst_o, (k <= RC + 1) ? 8'h08 : 8'h00);
            chk($sformatf("cfg_isel[%0d]", k), isel_o, (k >= RC + 1) ? 8'h08 : 8'h00);
            chk($sformatf("cfg_fix[%0d]", k), fixhold_o, (k >= RC + 1) ? 8'h08 : 8'h00);
            chk($sformatf("cfg_done[%0d]", k), cfg_done, (k == LAT) ? 1'b1 : 1'b0);
            chk($sformatf("cfg_ready[%0d]", k), cfg_ready, (k > LAT) ? 1'b1 : 1'b0);
            chk($sformatf("mask_valid[%0d]", k), snap_valid, 1'b0);
            iqz_i = (k <= 3) ? 8'hCB : 8'hC3;
            @(negedge IQC);
        end
        for (int k = 0; k < 3; k++) begin
            chk("mask_valid_after", snap_valid, 1'b0);
            @(negedge IQC);
        end

        // Bad index on the 6-cell bank, then a good one
        for (int j = 6; j <= 7; j++) begin
            chk("bad_ready_pre", cfg_ready_b, 1'b1);
            cfg_valid_b = 1; cfg_idx_b = 3'(j); cfg_isel_b = 1; cfg_fixhold_b = 1;
            @(negedge IQC);
            cfg_valid_b = 0;
            chk("bad_err", cfg_err_b, 1'b1);
            chk("bad_ready", cfg_ready_b, 1'b1);
            chk("bad_isel", isel_b, 6'h00);
            chk("bad_fix", fixhold_b, 6'h00);
            chk("bad_rst", cell_rst_b, 6'h00);
            @(negedge IQC);
            chk("bad_err_clr", cfg_err_b, 1'b0);
        end
        cfg_valid_b = 1; cfg_idx_b = 5; cfg_isel_b = 0; cfg_fixhold_b = 1;
        @(negedge IQC);
        cfg_valid_b = 0;
        for (int k = 1; k <= LAT; k++) begin
            chk($sformatf("b_done[%0d]", k), cfg_done_b, (k == LAT) ? 1'b1 : 1'b0);
            chk($sformatf("b_rst[%0d]", k), cell_rst_b, (k <= RC + 1) ? 6'h20 : 6'h00);
            chk($sformatf("b_fix[%0d]", k), fixhold_b, (k >= RC + 1) ? 6'h20 : 6'h00);
            @(negedge IQC);
        end

        // Abort during SETTLE
        cfg_valid = 1; cfg_idx = 2; cfg_isel = 1; cfg_fixhold = 0;
        @(negedge IQC);
        cfg_valid = 0;
        repeat (4) @(negedge IQC);
        chk("abort_pre_rst", cell_rst_o, 8'h00);
        chk("abort_pre_isel", isel_o, 8'h0C);
        chk("abort_pre_fix", fixhold_o, 8'h08);
        iqz_i = 8'h00;
        QRT = 1'b1;
        #1;
        chk("abort_isel", isel_o, 8'h00);
        chk("abort_fix", fixhold_o, 8'h00);
        chk("abort_rst", cell_rst_o, 8'hFF);
        chk("abort_ready", cfg_ready, 1'b0);
        chk("abort_snap_valid", snap_valid, 1'b0);
        chk("abort_snap_data", snap_data, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge IQC);
            chk("abort_no_done", cfg_done, 1'b0);
        end
        QRT = 1'b0;
        @(negedge IQC);
        chk("abort_rel_rst", cell_rst_o, 8'h00);
        chk("abort_rel_ready", cfg_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("abort_no_done_after", cfg_done, 1'b0);
            @(negedge IQC);
        end

        // Randomized run against a timeline model
        have = 0; acc = 0; midx = 0; m_isel_new = 0; m_fix_new = 0;
        m_isel = 0; m_fix = 0; m_samp = 0; m_last = 0; m_valid = 0;
        for (int n = 0; n < 600; n++) begin
            seq = have && (n > acc) && (n <= acc + LAT);
            if (have && n == acc + RC + 1) begin
                m_isel[midx] = m_isel_new;
                m_fix[midx]  = m_fix_new;
            end
            exp_rst = (have && n >= acc + 1 && n <= acc + RC + 1) ? (8'h01 << midx) : 8'h00;
            chk("rnd_rst", cell_rst_o, exp_rst);
            chk("rnd_isel", isel_o, m_isel);
            chk("rnd_fix", fixhold_o, m_fix);
            chk("rnd_done", cfg_done, (have && n == acc + LAT) ? 1'b1 : 1'b0);
            chk("rnd_ready", cfg_ready, seq ? 1'b0 : 1'b1);
            chk("rnd_err", cfg_err, 1'b0);
            chk("rnd_snap_valid", snap_valid, m_valid);
            chk("rnd_snap_data", snap_data, m_last);

            cfg_valid   = ($urandom_range(0, 3) == 0);
            cfg_idx     = 3'($urandom_range(0, 7));
            cfg_isel    = 1'($urandom_range(0, 1));
            cfg_fixhold = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) iqz_i = 8'($urandom);
            if (seq && $urandom_range(0, 1) == 1) iqz_i[midx] = ~iqz_i[midx];
            snap_ready  = 1'($urandom_range(0, 1));

            m    = seq ? (8'h01 << midx) : 8'h00;
            m_in = (m_samp & ~m) | (m_last & m);
            if (m_valid) begin
                if (snap_ready) m_valid = 0;
            end else if (m_in != m_last) begin
                m_valid = 1;
                m_last  = m_in;
            end
            m_samp = iqz_i;

            if (!seq && cfg_valid) begin
                have = 1; acc = n; midx = cfg_idx;
                m_isel_new = cfg_isel; m_fix_new = cfg_fixhold;
            end
            @(negedge IQC);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
